// File: rtl/term_writer.sv
// Terminal byte stream to character-memory writer: printable bytes, CR/LF/BS, ESC[H and ESC[2J.
// Latency: a printable write appears one cycle after acceptance; line and screen clears write one cell per cycle.
// Backpressure: rx_ready is low while a write or clear is in progress.
module term_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cur_col,
    output logic [5:0]        cur_row,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, WRITE, ESC, CSI, CSI2, CLR_LINE, CLR_SCR
    } state_t;

    typedef struct packed {
        logic [5:0] row;
        logic [6:0] col;
    } cursor_t;

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [5:0]        LAST_ROW = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [CNT_W-1:0]  LINE_N   = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]  CELL_N   = CNT_W'(COLS * ROWS);
    localparam logic [7:0]        SPACE    = 8'h20;

    state_t              state, state_nxt;
    cursor_t             cur, cur_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                wr_en_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [7:0]          dat_nxt;
    logic                rdy_nxt;
    logic                busy_nxt;

    logic                accept;
    logic [5:0]          row_inc;
    logic [ADDR_W-1:0]   line_base;
    logic [ADDR_W-1:0]   cell_addr;

    assign accept    = rx_valid && rx_ready;
    assign row_inc   = (cur.row == LAST_ROW) ? 6'd0 : cur.row + 6'd1;
    assign line_base = ADDR_W'(cur.row) * COLS_A;
    assign cell_addr = line_base + ADDR_W'(cur.col);
    assign cur_col   = cur.col;
    assign cur_row   = cur.row;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            cnt      <= cnt_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= addr_nxt;
            wr_data  <= dat_nxt;
            rx_ready <= rdy_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        cnt_nxt   = cnt;
        wr_en_nxt = 1'b0;
        addr_nxt  = wr_addr;
        dat_nxt   = wr_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        wr_en_nxt = 1'b1;
                        addr_nxt  = cell_addr;
                        dat_nxt   = rx_data;
                        state_nxt = WRITE;
                        if (cur.col == LAST_COL) begin
                            cur_nxt.col = 7'd0;
                            cur_nxt.row = row_inc;
                        end else begin
                            cur_nxt.col = cur.col + 7'd1;
                        end
                    end else begin
                        case (rx_data)
                            8'h0A: begin
                                cur_nxt.row = row_inc;
                                cnt_nxt     = '0;
                                state_nxt   = CLR_LINE;
                            end
                            8'h0D: cur_nxt.col = 7'd0;
                            8'h08: if (cur.col != 7'd0) cur_nxt.col = cur.col - 7'd1;
                            8'h1B: state_nxt = ESC;
                            default: ;
                        endcase
                    end
                end
            end
            // Column 0 after a printable write can only mean the cursor wrapped.
            WRITE: begin
                if (cur.col == 7'd0) begin
                    cnt_nxt   = '0;
                    state_nxt = CLR_LINE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ESC: begin
                if (accept) state_nxt = (rx_data == 8'h5B) ? CSI : IDLE;
            end
            CSI: begin
                if (accept) begin
                    state_nxt = IDLE;
                    if (rx_data == 8'h48) cur_nxt = '0;
                    else if (rx_data == 8'h32) state_nxt = CSI2;
                end
            end
            CSI2: begin
                if (accept) begin
                    if (rx_data == 8'h4A) begin
                        cnt_nxt   = '0;
                        state_nxt = CLR_SCR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            // Counters run one past the last cell so the final write is still seen with busy high.
            CLR_LINE: begin
                if (cnt == LINE_N) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = line_base + ADDR_W'(cnt);
                    dat_nxt   = SPACE;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            CLR_SCR: begin
                if (cnt == CELL_N) begin
                    cnt_nxt   = '0;
                    cur_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    wr_en_nxt = 1'b1;
                    addr_nxt  = ADDR_W'(cnt);
                    dat_nxt   = SPACE;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        rdy_nxt  = (state_nxt == IDLE) || (state_nxt == ESC) ||
                   (state_nxt == CSI)  || (state_nxt == CSI2);
        busy_nxt = (state_nxt == CLR_LINE) || (state_nxt == CLR_SCR);
    end

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: directed scenarios plus random bytes against a screen-level model.
module tb_term_writer;
    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int AW    = 13;
    localparam int NCELL = COLS * ROWS;

    logic          clk25 = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [6:0]    cur_col;
    logic [5:0]    cur_row;
    logic          busy;

    term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk25(clk25), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        int addr;
        int dat;
        bit clr;
    } wexp_t;

    wexp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int clr_seen = 0;
    int m_col = 0, m_row = 0, m_mode = 0;
    int imm_col = 0, imm_row = 0;

    function automatic void push(input int a, input int d, input bit c);
        wexp_t e;
        e.addr = a; e.dat = d; e.clr = c;
        q.push_back(e);
    endfunction

    function automatic void line_adv();
        m_row = (m_row + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push(m_row * COLS + c, 32, 1'b1);
    endfunction

    // Screen model: mode 0 text, 1 after ESC, 2 after ESC[, 3 after ESC[2.
    function automatic void model(input int b);
        bit scr;
        scr = 1'b0;
        case (m_mode)
            0: begin
                if (b >= 32 && b <= 126) begin
                    push(m_row * COLS + m_col, b, 1'b0);
                    m_col++;
                    if (m_col == COLS) begin
                        m_col = 0;
                        line_adv();
                    end
                end else if (b == 10) line_adv();
                else if (b == 13) m_col = 0;
                else if (b == 8) begin
                    if (m_col > 0) m_col--;
                end else if (b == 27) m_mode = 1;
            end
            1: m_mode = (b == 'h5B) ? 2 : 0;
            2: begin
                m_mode = 0;
                if (b == 'h48) begin m_col = 0; m_row = 0; end
                else if (b == 'h32) m_mode = 3;
            end
            default: begin
                m_mode = 0;
                if (b == 'h4A) scr = 1'b1;
            end
        endcase
        imm_col = m_col;
        imm_row = m_row;
        if (scr) begin
            for (int a = 0; a < NCELL; a++) push(a, 32, 1'b1);
            m_col = 0;
            m_row = 0;
        end
    endfunction

    always @(negedge clk25) begin
        if (rst_n && wr_en) begin
            compared++;
            assert (q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write addr=%0d data=%02h want=no write", wr_addr, wr_data);
            end
            if (q.size() != 0) begin
                wexp_t e;
                e = q.pop_front();
                compared++;
                assert (wr_addr === AW'(e.addr) && wr_data === 8'(e.dat) && busy === logic'(e.clr) &&
                        (!e.clr || rx_ready === 1'b0)) else begin
                    mismatched++;
                    $error("FAIL write got addr=%0d data=%02h busy=%b rdy=%b want addr=%0d data=%02h busy=%b",
                           wr_addr, wr_data, busy, rx_ready, e.addr, e.dat, e.clr);
                end
                if (e.clr) clr_seen++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk25);
        rx_data = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 20000) begin
            @(negedge clk25);
            t++;
        end
        compared++;
        assert (rx_ready === 1'b1) else begin
            mismatched++;
            $error("FAIL rx_ready_timeout byte=%02h got=%b want=1", b, rx_ready);
        end
        if (rx_ready === 1'b1) begin
            @(posedge clk25);
            model(int'(b));
            #1;
            rx_valid = 1'b0;
            compared++;
            assert (cur_col === 7'(imm_col) && cur_row === 6'(imm_row)) else begin
                mismatched++;
                $error("FAIL cursor_after byte=%02h got=(%0d,%0d) want=(%0d,%0d)",
                       b, cur_col, cur_row, imm_col, imm_row);
            end
        end else begin
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string tag);
        int t;
        t = 0;
        while ((q.size() != 0 || busy !== 1'b0 || rx_ready !== 1'b1) && t < 20000) begin
            @(negedge clk25);
            t++;
        end
        compared++;
        assert (q.size() == 0 && busy === 1'b0) else begin
            mismatched++;
            $error("FAIL %s_drain got pending=%0d busy=%b want pending=0 busy=0", tag, q.size(), busy);
        end
        compared++;
        assert (cur_col === 7'(m_col) && cur_row === 6'(m_row)) else begin
            mismatched++;
            $error("FAIL %s_cursor got=(%0d,%0d) want=(%0d,%0d)", tag, cur_col, cur_row, m_col, m_row);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        compared++;
        assert (wr_en === 1'b0 && wr_addr === '0 && wr_data === 8'h00 && cur_col === 7'd0 &&
                cur_row === 6'd0 && busy === 1'b0 && rx_ready === 1'b0) else begin
            mismatched++;
            $error("FAIL %s got en=%b addr=%0d data=%02h col=%0d row=%0d busy=%b rdy=%b want all zero",
                   tag, wr_en, wr_addr, wr_data, cur_col, cur_row, busy, rx_ready);
        end
    endtask

    task automatic release_reset();
        @(negedge clk25);
        rst_n = 1'b1;
        @(posedge clk25);
        #1;
        compared++;
        assert (rx_ready === 1'b1 && wr_en === 1'b0) else begin
            mismatched++;
            $error("FAIL ready_after_reset got rdy=%b en=%b want rdy=1 en=0", rx_ready, wr_en);
        end
    endtask

    initial begin
        int t;
        int base;
        int r;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk25);
        check_reset_outs("reset_values");
        release_reset();

        // Two printable bytes
        send(8'h41);
        send(8'h42);
        wait_quiet("ab");

        // Home, then backspace at column 0 stays put
        send(8'h1B); send(8'h5B); send(8'h48);
        send(8'h08);
        wait_quiet("bs_col0");

        // Reach (79,59), then autowrap onto row 0
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send(8'h61);
        wait_quiet("to_corner");
        send(8'h5A);
        wait_quiet("wrap_corner");

        // (5,3) then CR, LF clears row 4
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h63);
        wait_quiet("at_5_3");
        send(8'h0D);
        send(8'h0A);
        wait_quiet("cr_lf");

        // Clear screen
        send(8'h1B); send(8'h5B); send(8'h32); send(8'h4A);
        wait_quiet("clr_scr");

        // Aborted escape, then write, then home
        send(8'h44);
        send(8'h1B); send(8'h78);
        send(8'h51);
        send(8'h1B); send(8'h5B); send(8'h48);
        wait_quiet("esc_misc");

        // Random mix of bytes
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      b = 8'($urandom_range(32, 126));
            else if (r < 65) b = 8'h0D;
            else if (r < 70) b = 8'h0A;
            else if (r < 75) b = 8'h08;
            else if (r < 80) b = 8'h1B;
            else if (r < 85) b = 8'h5B;
            else if (r < 88) b = 8'h32;
            else if (r < 90) b = 8'h48;
            else if (r < 91) b = 8'h4A;
            else             b = 8'($urandom_range(0, 255));
            send(b);
        end
        wait_quiet("random");
        send(8'h1B); send(8'h1B);
        wait_quiet("esc_flush");

        // Reset in the middle of a screen clear
        base = clr_seen;
        send(8'h1B); send(8'h5B); send(8'h32); send(8'h4A);
        t = 0;
        while (clr_seen < base + 2000 && t < 10000) begin
            @(negedge clk25);
            t++;
        end
        compared++;
        assert (clr_seen >= base + 2000) else begin
            mismatched++;
            $error("FAIL clr_progress got=%0d want=%0d", clr_seen - base, 2000);
        end
        #5;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_col = 0; m_row = 0; m_mode = 0;
        check_reset_outs("async_abort");
        repeat (3) @(negedge clk25);
        check_reset_outs("held_reset");
        release_reset();
        repeat (30) @(negedge clk25);
        wait_quiet("after_abort");
        send(8'h52);
        wait_quiet("post_reset_write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
